replay_buffer_param: RTL and testbench

- Parametrised data-link-layer replay buffer, next generation of the 16-bit single-mode fifo.
- Each accepted transmit word is stored with an assigned sequence number.
- ACKs purge acknowledged entries. A NAK or a replay timeout streams all unacknowledged entries back out through a ready/valid handshake.
- Tracks the replay count and flags rollover for link retrain. Sits between the transaction layer's transmit path and the link framer.

---
 rtl/replay_pkg.sv | 25 ++
 rtl/replay_mem.sv | 34 +++
 rtl/replay_buffer_param.sv | 220 ++++++++++++++++++++++
 tb/tb_replay_buffer_param.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/replay_pkg.sv
// Shared types and helpers for the data-link replay buffer.
package replay_pkg;

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_ACK  = 2'b01;
  localparam logic [1:0] ACK_NAK  = 2'b10;

  localparam int REPLAY_NUM_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_e;

  // (a - b) mod 2^w, for sequence numbers up to 32 bits wide
  function automatic logic [31:0] seq_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/replay_mem.sv
// Replay storage: simple dual-port register array, synchronous write,
// registered read (the read register doubles as the data_out register).
module replay_mem
  import replay_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter int  WIDTH  = 28,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/replay_buffer_param.sv
// Data-link replay buffer: stores sequenced transmit words, purges on ACK,
// replays all unacknowledged words on NAK or replay-timer expiry.
module replay_buffer_param
  import replay_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  DEPTH  = 16,
  parameter int  SEQ_W  = 12,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  output logic [SEQ_W-1:0]  wr_seq,
  input  logic [1:0]        ack_nak,
  input  logic [SEQ_W-1:0]  ack_seq,
  input  logic              tim_out,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rdy,
  output logic              rep,
  output logic [SEQ_W-1:0]  num_packets_to_replay,
  output logic [ADDR_W-1:0] replay_index,
  output logic              replay_rollover,
  output logic              seq_err,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam int              WORD_W   = SEQ_W + DATA_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       head_q, head_d;
  logic [ADDR_W-1:0]       tail_q, tail_d;
  logic [ADDR_W:0]         count_q, count_d;
  logic [SEQ_W-1:0]        next_seq_q, next_seq_d;
  logic [REPLAY_NUM_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]              pend_q, pend_d;
  logic [SEQ_W-1:0]        pend_seq_q, pend_seq_d;
  logic [SEQ_W-1:0]        num_q, num_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic                    rdy_q, rdy_d;
  logic                    seq_err_q, seq_err_d;
  logic                    roll_q, roll_d;

  logic                    wr_acc;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_rd_addr;
  logic [WORD_W-1:0]       rd_word;
  logic [SEQ_W-1:0]        head_seq;
  logic [SEQ_W-1:0]        diff;
  logic [SEQ_W-1:0]        cmd_seq;
  logic [1:0]              cmd;
  logic [ADDR_W:0]         purge;
  logic [REPLAY_NUM_W-1:0] rcnt_base;
  logic                    last_entry;

  replay_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (tail_q),
    .wr_data ({next_seq_q, data_in}),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (rd_word)
  );

  // Sequence numbers are contiguous, so the oldest one follows from next_seq and count.
  assign head_seq   = next_seq_q - SEQ_W'(count_q);
  // No writes occur during a replay, so the newest stored word marks the end of the stream.
  assign last_entry = (rd_word[WORD_W-1:DATA_W] == next_seq_q - SEQ_W'(1));

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    next_seq_d  = next_seq_q;
    rcnt_d      = rcnt_q;
    pend_d      = pend_q;
    pend_seq_d  = pend_seq_q;
    num_d       = num_q;
    idx_d       = idx_q;
    rdy_d       = rdy_q;
    seq_err_d   = 1'b0;
    roll_d      = 1'b0;
    wr_acc      = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = head_q;
    cmd         = ACK_NONE;
    cmd_seq     = ack_seq;
    diff        = '0;
    purge       = '0;
    rcnt_base   = rcnt_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (pend_q != ACK_NONE) begin
            cmd     = pend_q;
            cmd_seq = pend_seq_q;
            pend_d  = ACK_NONE;
          end else begin
            cmd     = ack_nak;
            cmd_seq = ack_seq;
          end

          if (cmd == ACK_ACK || cmd == ACK_NAK) begin
            diff = SEQ_W'(seq_diff(32'(cmd_seq), 32'(head_seq), SEQ_W));
            if (count_q != '0 && diff < SEQ_W'(count_q)) begin
              purge  = diff[ADDR_W:0] + (ADDR_W+1)'(1);
              head_d = head_q + purge[ADDR_W-1:0];
              if (cmd == ACK_ACK) rcnt_base = '0;
            end else begin
              seq_err_d = 1'b1;
            end
          end

          wr_acc = wr && (count_q != CNT_FULL);
          if (wr_acc) begin
            tail_d     = tail_q + ADDR_W'(1);
            next_seq_d = next_seq_q + SEQ_W'(1);
          end
          count_d = count_q + {{ADDR_W{1'b0}}, wr_acc} - purge;

          rcnt_d = rcnt_base;
          if ((cmd == ACK_NAK || tim_out) && count_q != '0 && count_d != '0) begin
            state_d = LOAD;
            roll_d  = (rcnt_base == '1);
            rcnt_d  = rcnt_base + REPLAY_NUM_W'(1);
          end
        end

        LOAD, SEND: begin
          // Deferred ACK/NAK: newest wins, but a pending NAK is never downgraded.
          if (ack_nak == ACK_NAK) begin
            pend_d     = ACK_NAK;
            pend_seq_d = ack_seq;
          end else if (ack_nak == ACK_ACK && pend_q != ACK_NAK) begin
            pend_d     = ACK_ACK;
            pend_seq_d = ack_seq;
          end

          if (state_q == LOAD) begin
            num_d       = SEQ_W'(count_q);
            idx_d       = '0;
            mem_rd_en   = 1'b1;
            mem_rd_addr = head_q;
            rdy_d       = 1'b1;
            state_d     = SEND;
          end else if (rdy_q && out_ready) begin
            if (last_entry) begin
              rdy_d   = 1'b0;
              state_d = IDLE;
            end else begin
              idx_d       = idx_q + ADDR_W'(1);
              mem_rd_en   = 1'b1;
              mem_rd_addr = head_q + idx_q + ADDR_W'(1);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      next_seq_q <= '0;
      rcnt_q     <= '0;
      pend_q     <= ACK_NONE;
      pend_seq_q <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      rdy_q      <= 1'b0;
      seq_err_q  <= 1'b0;
      roll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      next_seq_q <= next_seq_d;
      rcnt_q     <= rcnt_d;
      pend_q     <= pend_d;
      pend_seq_q <= pend_seq_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      rdy_q      <= rdy_d;
      seq_err_q  <= seq_err_d;
      roll_q     <= roll_d;
    end
  end

  assign wr_seq                = next_seq_q;
  assign data_out              = rd_word[DATA_W-1:0];
  assign rdy                   = rdy_q;
  assign rep                   = (state_q != IDLE);
  assign num_packets_to_replay = num_q;
  assign replay_index          = idx_q;
  assign replay_rollover       = roll_q;
  assign seq_err               = seq_err_q;
  assign count                 = count_q;
  assign empty                 = (count_q == '0);
  assign full                  = (count_q == CNT_FULL);

endmodule

// File: tb/tb_replay_buffer_param.sv
// Bench for replay_buffer_param: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_replay_buffer_param;
  import replay_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int SEQ_W  = 12;
  localparam int ADDR_W = 3;
  localparam int SMASK  = (1 << SEQ_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              wr = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [1:0]        ack_nak = ACK_NONE;
  logic [SEQ_W-1:0]  ack_seq = '0;
  logic              tim_out = 1'b0;
  logic              out_ready = 1'b0;
  logic [SEQ_W-1:0]  wr_seq;
  logic [DATA_W-1:0] data_out;
  logic              rdy, rep, replay_rollover, seq_err, empty, full;
  logic [SEQ_W-1:0]  num_packets_to_replay;
  logic [ADDR_W-1:0] replay_index;
  logic [ADDR_W:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  replay_buffer_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .data_in(data_in), .wr_seq(wr_seq),
    .ack_nak(ack_nak), .ack_seq(ack_seq), .tim_out(tim_out), .out_ready(out_ready),
    .data_out(data_out), .rdy(rdy), .rep(rep),
    .num_packets_to_replay(num_packets_to_replay), .replay_index(replay_index),
    .replay_rollover(replay_rollover), .seq_err(seq_err), .count(count),
    .empty(empty), .full(full)
  );

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int m_nseq, m_state, m_rc, m_pend, m_pseq, m_num, m_idx, m_rdy, m_dout, m_err, m_roll;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_nseq = 0; m_state = 0; m_rc = 0; m_pend = 0; m_pseq = 0;
    m_num = 0; m_idx = 0; m_rdy = 0; m_dout = 0; m_err = 0; m_roll = 0;
  endtask

  task automatic model_capture();
    if (ack_nak == ACK_NAK) begin
      m_pend = 2; m_pseq = int'(ack_seq);
    end else if (ack_nak == ACK_ACK && m_pend != 2) begin
      m_pend = 1; m_pseq = int'(ack_seq);
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs currently driven.
  task automatic model_step();
    int cnt, d, cmd, cseq;
    ent_t e;
    m_err = 0; m_roll = 0;
    if (!en) return;
    case (m_state)
      0: begin
        if (m_pend != 0) begin
          cmd = m_pend; cseq = m_pseq; m_pend = 0;
        end else begin
          cmd = int'(ack_nak); cseq = int'(ack_seq);
        end
        cnt = q.size();
        if (cmd == 1 || cmd == 2) begin
          d = (cnt > 0) ? ((cseq - int'(q[0].seq)) & SMASK) : 0;
          if (cnt > 0 && d < cnt) begin
            for (int i = 0; i <= d; i++) void'(q.pop_front());
            if (cmd == 1) m_rc = 0;
          end else begin
            m_err = 1;
          end
        end
        if (wr && cnt < DEPTH) begin
          e.seq = 32'(m_nseq); e.data = 32'(data_in);
          q.push_back(e);
          m_nseq = (m_nseq + 1) & SMASK;
        end
        if ((cmd == 2 || tim_out) && cnt > 0 && q.size() > 0) begin
          m_roll = (m_rc == 3) ? 1 : 0;
          m_rc = (m_rc + 1) % 4;
          m_state = 1;
        end
      end
      1: begin
        model_capture();
        m_num = q.size(); m_idx = 0; m_rdy = 1; m_dout = int'(q[0].data); m_state = 2;
      end
      default: begin
        model_capture();
        if (m_rdy != 0 && out_ready) begin
          if (m_idx == m_num - 1) begin
            m_rdy = 0; m_state = 0;
          end else begin
            m_idx++; m_dout = int'(q[m_idx].data);
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("wr_seq", 32'(wr_seq), 32'(m_nseq));
    chk("rep", 32'(rep), 32'(m_state != 0));
    chk("rdy", 32'(rdy), 32'(m_rdy));
    chk("seq_err", 32'(seq_err), 32'(m_err));
    chk("replay_rollover", 32'(replay_rollover), 32'(m_roll));
    chk("num_packets", 32'(num_packets_to_replay), 32'(m_num));
    chk("replay_index", 32'(replay_index), 32'(m_idx));
    if (m_rdy != 0) chk("data_out", 32'(data_out), 32'(m_dout));
  endtask

  // Inputs are driven at the falling edge; the model steps with the DUT edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic quiet();
    en = 1'b1; wr = 1'b0; ack_nak = ACK_NONE; tim_out = 1'b0; out_ready = 1'b1;
  endtask

  task automatic send_cmd(input logic [1:0] c, input int s);
    ack_nak = c; ack_seq = SEQ_W'(s);
    step(1);
    ack_nak = ACK_NONE;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_data_out", 32'(data_out), 32'd0);
    rst = 1'b1;
    quiet();

    // Fill five words, then ACK and NAK
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; data_in = DATA_W'(i);
      step(1);
    end
    wr = 1'b0;
    chk("wr_seq_after_5", 32'(wr_seq), 32'd5);
    chk("count_after_5", 32'(count), 32'd5);
    send_cmd(ACK_ACK, 1);
    chk("count_after_ack1", 32'(count), 32'd3);
    chk("model_head_seq", q[0].seq, 32'd2);
    send_cmd(ACK_NAK, 2);
    chk("nak_count", 32'(count), 32'd2);
    chk("nak_rep", 32'(rep), 32'd1);
    step(1);
    chk("nak_num", 32'(num_packets_to_replay), 32'd2);
    chk("nak_word0", 32'(data_out), 32'h3);
    chk("nak_idx0", 32'(replay_index), 32'd0);
    step(1);
    chk("nak_word1", 32'(data_out), 32'h4);
    chk("nak_idx1", 32'(replay_index), 32'd1);
    step(1);
    chk("nak_done_rep", 32'(rep), 32'd0);

    // Stall mid-stream
    tim_out = 1'b1; step(1); tim_out = 1'b0;
    step(2);
    out_ready = 1'b0;
    step(3);
    chk("stall_word", 32'(data_out), 32'h4);
    chk("stall_idx", 32'(replay_index), 32'd1);
    chk("stall_rdy", 32'(rdy), 32'd1);
    out_ready = 1'b1;
    step(1);
    chk("stall_done_rep", 32'(rep), 32'd0);

    // Full / overflow / empty ACK
    send_cmd(ACK_ACK, 4);
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1; data_in = DATA_W'(16 + i);
      step(1);
    end
    wr = 1'b0;
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd8);
    chk("full_wr_seq", 32'(wr_seq), 32'd13);
    send_cmd(ACK_ACK, 12);
    chk("ack_all_empty", 32'(empty), 32'd1);
    send_cmd(ACK_ACK, 3);
    chk("empty_ack_seq_err", 32'(seq_err), 32'd1);
    step(1);
    chk("seq_err_pulse_end", 32'(seq_err), 32'd0);

    // Replay counter rollover and clearing by ACK
    for (int i = 0; i < 2; i++) begin
      wr = 1'b1; data_in = DATA_W'(32 + i);
      step(1);
    end
    wr = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tim_out = 1'b1; step(1); tim_out = 1'b0;
      chk("rollover_k", 32'(replay_rollover), 32'(k == 3));
      step(4);
    end
    send_cmd(ACK_ACK, 13);
    tim_out = 1'b1; step(1); tim_out = 1'b0;
    chk("rollover_after_ack", 32'(replay_rollover), 32'd0);
    step(4);

    // ACK during SEND is deferred to the first IDLE cycle
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; data_in = DATA_W'(48 + i);
      step(1);
    end
    wr = 1'b0;
    tim_out = 1'b1; step(1); tim_out = 1'b0;
    out_ready = 1'b0;
    step(1);
    send_cmd(ACK_ACK, 15);
    step(1);
    chk("deferred_count_held", 32'(count), 32'd4);
    out_ready = 1'b1;
    step(4);
    chk("deferred_rep_end", 32'(rep), 32'd0);
    chk("deferred_count_before", 32'(count), 32'd4);
    step(1);
    chk("deferred_count_after", 32'(count), 32'd2);

    // Asynchronous reset during SEND
    tim_out = 1'b1; step(1); tim_out = 1'b0;
    step(1);
    chk("pre_reset_rdy", 32'(rdy), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_rdy", 32'(rdy), 32'd0);
    chk("async_rst_rep", 32'(rep), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_wr_seq", 32'(wr_seq), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    compare_all();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      en        = ($urandom % 16) != 0;
      wr        = $urandom % 2;
      data_in   = DATA_W'($urandom);
      tim_out   = ($urandom % 20) == 0;
      out_ready = ($urandom % 4) != 0;
      r = int'($urandom % 10);
      ack_nak = (r < 6) ? ACK_NONE : (r < 8) ? ACK_ACK : (r < 9) ? ACK_NAK : 2'b11;
      if (q.size() > 0 && ($urandom % 4) != 0)
        ack_seq = SEQ_W'(int'(q[0].seq) + int'($urandom_range(0, q.size())));
      else
        ack_seq = SEQ_W'($urandom);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
